// File: rtl/vend_scheduler.sv
// Round-robin arbiter sharing one drink dispenser among N_REQ panels:
// price check, timed dispense, one-cycle done/error pulse, saturating stats.
module vend_scheduler #(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned DISPENSE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [10*N_REQ-1:0]   pay_in,
    input  logic [8*N_REQ-1:0]    code,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      error,
    output logic                  dispense_en,
    output logic [7:0]            dispense_code,
    output logic                  busy,
    output logic [15:0]           vend_count,
    output logic [7:0]            err_count
);

    localparam int unsigned IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DISPENSE,
        RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx_r;
    logic [9:0]      pay_r;
    logic [7:0]      code_r;
    logic [7:0]      cnt;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    int unsigned     slot;
    logic [IW-1:0]   next_ptr;

    function automatic logic price_ok(input logic [7:0] c, input logic [9:0] p);
        case (c)
            8'hC1, 8'hC2, 8'hC3: return p == 10'h03F;
            8'hD4, 8'hD5:        return p == 10'h3FF;
            8'hB6, 8'hB7:        return p == 10'h0FF;
            default:             return 1'b0;
        endcase
    endfunction

    // Scan offsets from farthest to nearest so the slot closest to rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        slot        = 0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            slot = 32'(rr_ptr) + i - 1;
            if (slot >= N_REQ) slot = slot - N_REQ;
            if (req[IW'(slot)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(slot);
            end
        end
    end

    assign next_ptr = (idx_r == IW'(N_REQ - 1)) ? '0 : idx_r + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            idx_r         <= '0;
            pay_r         <= '0;
            code_r        <= '0;
            cnt           <= '0;
            done          <= '0;
            error         <= '0;
            dispense_en   <= 1'b0;
            dispense_code <= '0;
            busy          <= 1'b0;
            vend_count    <= '0;
            err_count     <= '0;
        end else begin
            done  <= '0;
            error <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        idx_r  <= grant_idx;
                        pay_r  <= pay_in[32'(grant_idx)*10 +: 10];
                        code_r <= code[32'(grant_idx)*8 +: 8];
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (price_ok(code_r, pay_r)) begin
                        cnt           <= 8'(DISPENSE_CYCLES);
                        dispense_en   <= 1'b1;
                        dispense_code <= code_r;
                        state         <= DISPENSE;
                    end else begin
                        done[idx_r]  <= 1'b1;
                        error[idx_r] <= 1'b1;
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        rr_ptr       <= next_ptr;
                        state        <= RESP;
                    end
                end
                DISPENSE: begin
                    if (cnt == 8'd1) begin
                        dispense_en   <= 1'b0;
                        dispense_code <= '0;
                        done[idx_r]   <= 1'b1;
                        if (vend_count != '1) vend_count <= vend_count + 1'b1;
                        rr_ptr        <= next_ptr;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_scheduler.sv
// Directed bench for vend_scheduler (N_REQ=4, DISPENSE_CYCLES=8).
module tb_vend_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] pay_in;
    logic [31:0] code;
    logic [3:0]  done;
    logic [3:0]  error;
    logic        dispense_en;
    logic [7:0]  dispense_code;
    logic        busy;
    logic [15:0] vend_count;
    logic [7:0]  err_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_vend    = 0;
    int exp_err     = 0;
    int pulses;

    vend_scheduler #(.N_REQ(4), .DISPENSE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req(req), .pay_in(pay_in), .code(code),
        .done(done), .error(error), .dispense_en(dispense_en),
        .dispense_code(dispense_code), .busy(busy),
        .vend_count(vend_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_panel(input int p, input logic [7:0] c, input logic [9:0] v);
        code[p*8 +: 8]    = c;
        pay_in[p*10 +: 10] = v;
    endtask

    // Called in an IDLE cycle with panel p already requesting and guaranteed to win.
    task automatic serve(input int p, input logic [7:0] c, input bit ok, input bit drop);
        tick();
        chk("busy_check", 32'(busy), 1);
        chk("den_check", 32'(dispense_en), 0);
        chk("done_check", 32'(done), 0);
        chk("vend_pre", 32'(vend_count), exp_vend);
        chk("err_pre", 32'(err_count), exp_err);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                chk("den_on", 32'(dispense_en), 1);
                chk("dcode", 32'(dispense_code), 32'(c));
                chk("done_early", 32'(done), 0);
            end
        end
        tick();
        if (ok) exp_vend++;
        else if (exp_err < 255) exp_err++;
        chk("done_pulse", 32'(done), 32'd1 << p);
        chk("error_pulse", 32'(error), ok ? 32'd0 : (32'd1 << p));
        chk("den_off", 32'(dispense_en), 0);
        chk("dcode_off", 32'(dispense_code), 0);
        chk("vend_cnt", 32'(vend_count), exp_vend);
        chk("err_cnt", 32'(err_count), exp_err);
        if (drop) req[p] = 1'b0;
        tick();
        chk("done_clr", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        pay_in = '0;
        code   = '0;
        tick();
        tick();
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_den", 32'(dispense_en), 0);
        chk("rst_vend", 32'(vend_count), 0);
        rst = 1'b0;
        tick();

        // single vend: panel 1, C2 at exact price
        set_panel(1, 8'hC2, 10'h03F);
        req[1] = 1'b1;
        serve(1, 8'hC2, 1, 1);

        // wrong price: panel 0, D4 paid 0x0FF
        set_panel(0, 8'hD4, 10'h0FF);
        req[0] = 1'b1;
        serve(0, 8'hD4, 0, 1);

        // unknown code 0x00 on panel 3
        set_panel(3, 8'h00, 10'h3FF);
        req[3] = 1'b1;
        serve(3, 8'h00, 0, 1);

        // fairness: rr_ptr is 0 here; panel 0 keeps requesting after its first done
        set_panel(0, 8'hC1, 10'h03F);
        set_panel(1, 8'hD4, 10'h3FF);
        set_panel(2, 8'hB6, 10'h0FF);
        set_panel(3, 8'hC3, 10'h03F);
        req = 4'b1111;
        serve(0, 8'hC1, 1, 0);
        serve(1, 8'hD4, 1, 1);
        serve(2, 8'hB6, 1, 1);
        serve(3, 8'hC3, 1, 1);
        serve(0, 8'hC1, 1, 1);

        // mid-service change on panel 2
        set_panel(2, 8'hC3, 10'h03F);
        req[2] = 1'b1;
        tick();
        tick();
        chk("mid_den", 32'(dispense_en), 1);
        set_panel(2, 8'hB7, 10'h000);
        req[2] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("mid_dcode", 32'(dispense_code), 32'hC3);
        end
        tick();
        exp_vend++;
        chk("mid_done", 32'(done), 32'b0100);
        chk("mid_error", 32'(error), 0);
        chk("mid_vend", 32'(vend_count), exp_vend);
        tick();
        chk("mid_idle", 32'(busy), 0);

        // reset in DISPENSE cycle 3 (rr_ptr is 3 before reset)
        set_panel(3, 8'hD5, 10'h3FF);
        req[3] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_den", 32'(dispense_en), 1);
        rst = 1'b1;
        #1;
        chk("arst_den", 32'(dispense_en), 0);
        chk("arst_dcode", 32'(dispense_code), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_vend", 32'(vend_count), 0);
        chk("arst_err", 32'(err_count), 0);
        exp_vend = 0;
        exp_err  = 0;
        req = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done", 32'(done), 0);
        set_panel(1, 8'hB7, 10'h0FF);
        set_panel(3, 8'hD5, 10'h3FF);
        req = 4'b1010;
        serve(1, 8'hB7, 1, 1);
        serve(3, 8'hD5, 1, 1);

        // err_count saturation with panel 0 holding an invalid request
        set_panel(0, 8'h00, 10'h3FF);
        req[0] = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 2000 && pulses < 257; cyc++) begin
            tick();
            if (done[0]) begin
                pulses++;
                if (pulses == 1 || pulses == 255 || pulses == 257)
                    chk("err_sat", 32'(err_count), (pulses == 1) ? 32'd1 : 32'd255);
            end
        end
        req[0] = 1'b0;
        chk("sat_pulses", pulses, 257);
        chk("sat_vend", 32'(vend_count), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
